// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the data-memory load/store controller.
package dmem_pkg;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   typedef logic [0:0] state_t;
   localparam state_t ST_IDLE  = 1'b0;
   localparam state_t ST_SPLIT = 1'b1;

   // 16-bit mask so a straddling access yields both doubleword halves at once
   function automatic logic [15:0] be_gen(input logic [1:0] size, input logic [2:0] off);
      logic [15:0] base;
      case (size)
         SZ_B:    base = 16'h0001;
         SZ_H:    base = 16'h0003;
         SZ_W:    base = 16'h000F;
         default: base = 16'h00FF;
      endcase
      return base << off;
   endfunction

   function automatic logic [63:0] load_ext(input logic [63:0] data, input logic [1:0] size,
                                            input logic uns);
      logic [63:0] res;
      case (size)
         SZ_B:    res = uns ? {56'd0, data[7:0]}  : {{56{data[7]}},  data[7:0]};
         SZ_H:    res = uns ? {48'd0, data[15:0]} : {{48{data[15]}}, data[15:0]};
         SZ_W:    res = uns ? {32'd0, data[31:0]} : {{32{data[31]}}, data[31:0]};
         default: res = data;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/dmem_lsu_ctrl_if.sv
// Request/response bundle between the MEM stage and the data-memory controller.
interface dmem_lsu_ctrl_if #(
   parameter int XLEN   = 64,
   parameter int ADDR_W = 64
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [ADDR_W-1:0] req_addr;
   logic [XLEN-1:0]   req_wdata;
   logic              resp_valid;
   logic [XLEN-1:0]   resp_rdata;
   logic              resp_err;

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/dmem_bank.sv
// Single-port 64-bit RAM with byte enables and a registered read port.
module dmem_bank #(
   parameter int WORDS = 32,
   parameter int IDX_W = 5
) (
   input  logic             clk,
   input  logic             en,
   input  logic             we,
   input  logic [7:0]       be,
   input  logic [IDX_W-1:0] addr,
   input  logic [63:0]      wdata,
   output logic [63:0]      rdata
);
   logic [63:0] mem_q [WORDS];
   logic [63:0] rdata_q;

   // Storage is intentionally not reset
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int b = 0; b < 8; b++) begin
               if (be[b]) begin
                  mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
               end
            end
         end else begin
            rdata_q <= mem_q[addr];
         end
      end
   end

   assign rdata = rdata_q;
endmodule

// File: rtl/dmem_lsu_ctrl.sv
// Load/store front end over a banked data memory; straddling accesses take two cycles.
// Define DMEM_MISALIGN_TRAP_EN to reject misaligned accesses instead of splitting them.
module dmem_lsu_ctrl #(
   parameter int XLEN        = 64,
   parameter int DEPTH_BYTES = 256,
   parameter int ADDR_W      = 64
) (
   input  logic          clk,
   input  logic          rst_n,
   dmem_lsu_ctrl_if.slave bus
);
   import dmem_pkg::*;

   localparam int WORDS = DEPTH_BYTES / 8;
   localparam int IDX_W = $clog2(WORDS);

   logic              fire_s, err_s, req_ready_s;
   logic [3:0]        nbytes_s;
   logic [2:0]        off_s;
   logic [ADDR_W:0]   end_addr_s;
   logic [15:0]       be16_s;
   logic [127:0]      wd128_s;
   logic [IDX_W-1:0]  idx_s;
   logic              do_split_s;

   logic              bank_en_s, bank_we_s;
   logic [7:0]        bank_be_s;
   logic [IDX_W-1:0]  bank_idx_s;
   logic [63:0]       bank_wdata_s, bank_rdata_s;
   logic [63:0]       raw_s, ext_s;

   logic              ph_valid_q, ph_valid_d, ph_last_q, ph_last_d, ph_err_q, ph_err_d;
   logic              ph_we_q, ph_we_d, ph_uns_q, ph_uns_d;
   logic [2:0]        ph_off_q, ph_off_d;
   logic [1:0]        ph_size_q, ph_size_d;
   logic              resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
   logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
`ifndef DMEM_MISALIGN_TRAP_EN
   state_t            state_q, state_d;
   logic              ph_split_q, ph_split_d, sp_we_q, sp_we_d;
   logic [IDX_W-1:0]  sp_idx_q, sp_idx_d;
   logic [7:0]        sp_be_q, sp_be_d;
   logic [63:0]       sp_wdata_q, sp_wdata_d, part_lo_q, part_lo_d;
`endif

   // Accept-time geometry and range check; arithmetic is one bit wider so it cannot wrap
   always_comb begin
      nbytes_s   = 4'd1 << bus.req_size;
      off_s      = bus.req_addr[2:0];
      idx_s      = bus.req_addr[IDX_W+2:3];
      be16_s     = be_gen(bus.req_size, off_s);
      wd128_s    = {64'd0, 64'(bus.req_wdata)} << {off_s, 3'b000};
      end_addr_s = {1'b0, bus.req_addr} + (ADDR_W+1)'(nbytes_s) - (ADDR_W+1)'(1);
      err_s      = (end_addr_s >= (ADDR_W+1)'(DEPTH_BYTES)) ||
                   ((XLEN == 32) && (bus.req_size == SZ_D));
`ifdef DMEM_MISALIGN_TRAP_EN
      err_s      = err_s || ((off_s & (nbytes_s[2:0] - 3'd1)) != 3'd0);
      do_split_s = 1'b0;
      req_ready_s = 1'b1;
`else
      do_split_s = (({1'b0, off_s} + nbytes_s) > 4'd8) && !err_s;
      req_ready_s = (state_q == ST_IDLE);
`endif
      fire_s     = bus.req_valid && req_ready_s;
   end

   // Bank port: the pending second half of a split has priority over new requests
   always_comb begin
      bank_en_s    = 1'b0;
      bank_we_s    = bus.req_we;
      bank_be_s    = be16_s[7:0];
      bank_idx_s   = idx_s;
      bank_wdata_s = wd128_s[63:0];
`ifndef DMEM_MISALIGN_TRAP_EN
      if (state_q == ST_SPLIT) begin
         bank_en_s    = 1'b1;
         bank_we_s    = sp_we_q;
         bank_be_s    = sp_be_q;
         bank_idx_s   = sp_idx_q;
         bank_wdata_s = sp_wdata_q;
      end else
`endif
      if (fire_s && !err_s) begin
         bank_en_s = 1'b1;
      end else begin
         bank_en_s = 1'b0;
      end
   end

   dmem_bank #(.WORDS(WORDS), .IDX_W(IDX_W)) u_bank (
      .clk   (clk),
      .en    (bank_en_s),
      .we    (bank_we_s),
      .be    (bank_be_s),
      .addr  (bank_idx_s),
      .wdata (bank_wdata_s),
      .rdata (bank_rdata_s)
   );

   // In-flight request descriptor, consumed at the edge after its last bank access
   always_comb begin
      ph_valid_d = 1'b0;
      ph_last_d  = ph_last_q;
      ph_err_d   = ph_err_q;
      ph_we_d    = ph_we_q;
      ph_uns_d   = ph_uns_q;
      ph_off_d   = ph_off_q;
      ph_size_d  = ph_size_q;
`ifndef DMEM_MISALIGN_TRAP_EN
      ph_split_d = ph_split_q;
`endif
      if (fire_s) begin
         ph_valid_d = 1'b1;
         ph_last_d  = !do_split_s;
         ph_err_d   = err_s;
         ph_we_d    = bus.req_we;
         ph_uns_d   = bus.req_unsigned;
         ph_off_d   = off_s;
         ph_size_d  = bus.req_size;
`ifndef DMEM_MISALIGN_TRAP_EN
         ph_split_d = do_split_s;
      end else if (state_q == ST_SPLIT) begin
         ph_valid_d = 1'b1;
         ph_last_d  = 1'b1;
`endif
      end else begin
         ph_valid_d = 1'b0;
      end
   end

`ifndef DMEM_MISALIGN_TRAP_EN
   // Split bookkeeping: second-half bank command and the captured first read
   always_comb begin
      state_d    = ST_IDLE;
      sp_idx_d   = sp_idx_q;
      sp_be_d    = sp_be_q;
      sp_wdata_d = sp_wdata_q;
      sp_we_d    = sp_we_q;
      part_lo_d  = (state_q == ST_SPLIT) ? bank_rdata_s : part_lo_q;
      case (state_q)
         ST_IDLE:  state_d = (fire_s && do_split_s) ? ST_SPLIT : ST_IDLE;
         ST_SPLIT: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      if (fire_s) begin
         sp_idx_d   = idx_s + IDX_W'(1);
         sp_be_d    = be16_s[15:8];
         sp_wdata_d = wd128_s[127:64];
         sp_we_d    = bus.req_we;
      end else begin
         sp_idx_d   = sp_idx_q;
      end
   end
`endif

   // Response assembly: align, stitch split halves, extend; stores and errors return zero
   always_comb begin
      raw_s = bank_rdata_s >> {ph_off_q, 3'b000};
`ifndef DMEM_MISALIGN_TRAP_EN
      if (ph_split_q) begin
         raw_s = (part_lo_q >> {ph_off_q, 3'b000}) |
                 (bank_rdata_s << {(4'd8 - {1'b0, ph_off_q}), 3'b000});
      end else begin
         raw_s = bank_rdata_s >> {ph_off_q, 3'b000};
      end
`endif
      ext_s        = load_ext(raw_s, ph_size_q, ph_uns_q);
      resp_valid_d = ph_valid_q && ph_last_q;
      resp_err_d   = resp_valid_d && ph_err_q;
      if (resp_valid_d && !ph_err_q && !ph_we_q) begin
         resp_rdata_d = XLEN'(ext_s);
      end else begin
         resp_rdata_d = {XLEN{1'b0}};
      end
   end

   // State and response registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ph_valid_q   <= 1'b0;
         ph_last_q    <= 1'b0;
         ph_err_q     <= 1'b0;
         ph_we_q      <= 1'b0;
         ph_uns_q     <= 1'b0;
         ph_off_q     <= 3'd0;
         ph_size_q    <= 2'd0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= {XLEN{1'b0}};
`ifndef DMEM_MISALIGN_TRAP_EN
         state_q      <= ST_IDLE;
         ph_split_q   <= 1'b0;
         sp_we_q      <= 1'b0;
         sp_idx_q     <= {IDX_W{1'b0}};
         sp_be_q      <= 8'h00;
         sp_wdata_q   <= 64'd0;
         part_lo_q    <= 64'd0;
`endif
      end else begin
         ph_valid_q   <= ph_valid_d;
         ph_last_q    <= ph_last_d;
         ph_err_q     <= ph_err_d;
         ph_we_q      <= ph_we_d;
         ph_uns_q     <= ph_uns_d;
         ph_off_q     <= ph_off_d;
         ph_size_q    <= ph_size_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
`ifndef DMEM_MISALIGN_TRAP_EN
         state_q      <= state_d;
         ph_split_q   <= ph_split_d;
         sp_we_q      <= sp_we_d;
         sp_idx_q     <= sp_idx_d;
         sp_be_q      <= sp_be_d;
         sp_wdata_q   <= sp_wdata_d;
         part_lo_q    <= part_lo_d;
`endif
      end
   end

   assign bus.req_ready  = req_ready_s;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.resp_rdata = resp_rdata_q;
endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Directed bench for dmem_lsu_ctrl; the DMEM_MISALIGN_TRAP_EN build runs the trap sequence.
module tb_dmem_lsu_ctrl;
   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad = 0;
   int   lat_g;
   logic [63:0] rd_g;
   logic er_g, rdy_g, hold_g, seen;

   dmem_lsu_ctrl_if #(.XLEN(64), .ADDR_W(64)) bus ();

   dmem_lsu_ctrl #(.XLEN(64), .DEPTH_BYTES(256), .ADDR_W(64)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one request, wait (bounded) for its response and record what came back
   task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wd);
      int i;
      @(negedge clk);
      bus.req_valid    = 1'b1;
      bus.req_we       = we;
      bus.req_size     = sz;
      bus.req_unsigned = uns;
      bus.req_addr     = addr;
      bus.req_wdata    = wd;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      rdy_g = bus.req_ready;
      lat_g = -1;
      rd_g  = 64'hDEAD_DEAD_DEAD_DEAD;
      er_g  = 1'bx;
      i = 0;
      while (lat_g < 0 && i < 4) begin
         i++;
         @(posedge clk);
         #1;
         if (bus.resp_valid) begin
            lat_g = i;
            rd_g  = bus.resp_rdata;
            er_g  = bus.resp_err;
         end
      end
      @(posedge clk);
      #1;
      hold_g = bus.resp_valid;
   endtask

   initial begin
      rst_n = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_we = 1'b0;
      bus.req_size = 2'd0;
      bus.req_unsigned = 1'b0;
      bus.req_addr = 64'd0;
      bus.req_wdata = 64'd0;
      #12;
      chk("rst_ready", 64'(bus.req_ready), 64'd1);
      chk("rst_rvalid", 64'(bus.resp_valid), 64'd0);
      chk("rst_rdata", bus.resp_rdata, 64'd0);
      chk("rst_err", 64'(bus.resp_err), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

`ifndef DMEM_MISALIGN_TRAP_EN
      // doubleword store then load
      issue(1'b1, 2'd3, 1'b0, 64'h10, 64'h1122334455667788);
      chk("sd_lat", 64'(lat_g), 64'd1);
      chk("sd_err", 64'(er_g), 64'd0);
      chk("sd_rdata", rd_g, 64'd0);
      chk("sd_pulse", 64'(hold_g), 64'd0);
      issue(1'b0, 2'd3, 1'b0, 64'h10, 64'd0);
      chk("ld_lat", 64'(lat_g), 64'd1);
      chk("ld_data", rd_g, 64'h1122334455667788);

      // byte sign / zero extension
      issue(1'b1, 2'd0, 1'b0, 64'h10, 64'h00000000000000F4);
      issue(1'b0, 2'd0, 1'b0, 64'h10, 64'd0);
      chk("lb_data", rd_g, 64'hFFFFFFFFFFFFFFF4);
      issue(1'b0, 2'd0, 1'b1, 64'h10, 64'd0);
      chk("lbu_data", rd_g, 64'h00000000000000F4);

      // split store across 0x0F/0x10
      issue(1'b1, 2'd3, 1'b0, 64'h08, 64'h0807060504030201);
      issue(1'b1, 2'd2, 1'b0, 64'h0E, 64'h00000000AABBCCDD);
      chk("sw_split_ready", 64'(rdy_g), 64'd0);
      chk("sw_split_lat", 64'(lat_g), 64'd2);
      chk("sw_split_err", 64'(er_g), 64'd0);
      chk("sw_split_pulse", 64'(hold_g), 64'd0);
      issue(1'b0, 2'd2, 1'b1, 64'h0E, 64'd0);
      chk("lwu_split_lat", 64'(lat_g), 64'd2);
      chk("lwu_split_data", rd_g, 64'h00000000AABBCCDD);
      issue(1'b0, 2'd2, 1'b0, 64'h0E, 64'd0);
      chk("lw_split_data", rd_g, 64'hFFFFFFFFAABBCCDD);
      issue(1'b0, 2'd3, 1'b0, 64'h0C, 64'd0);
      chk("ld_split_data", rd_g, 64'h5566AABBCCDD0605);
      issue(1'b0, 2'd3, 1'b0, 64'h10, 64'd0);
      chk("ld_after_split", rd_g, 64'h112233445566AABB);

      // back-to-back loads: bytes 0x0D and 0x12 untouched by the split store
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_we = 1'b0;
      bus.req_size = 2'd0;
      bus.req_unsigned = 1'b1;
      bus.req_addr = 64'h0D;
      @(posedge clk);
      #1;
      chk("b2b_ready", 64'(bus.req_ready), 64'd1);
      @(negedge clk);
      bus.req_addr = 64'h12;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      chk("b2b_v1", 64'(bus.resp_valid), 64'd1);
      chk("b2b_byte0d", bus.resp_rdata, 64'h06);
      @(posedge clk);
      #1;
      chk("b2b_v2", 64'(bus.resp_valid), 64'd1);
      chk("b2b_byte12", bus.resp_rdata, 64'h66);

      // range boundary
      issue(1'b1, 2'd2, 1'b0, 64'hFC, 64'h000000005A5A5A5A);
      chk("sw_top_err", 64'(er_g), 64'd0);
      issue(1'b0, 2'd3, 1'b0, 64'hFC, 64'd0);
      chk("ld_oor_lat", 64'(lat_g), 64'd1);
      chk("ld_oor_err", 64'(er_g), 64'd1);
      chk("ld_oor_rdata", rd_g, 64'd0);
      chk("ld_oor_ready", 64'(rdy_g), 64'd1);
      issue(1'b1, 2'd3, 1'b0, 64'hFC, 64'h0123456789ABCDEF);
      chk("sd_oor_err", 64'(er_g), 64'd1);
      issue(1'b0, 2'd2, 1'b1, 64'hFC, 64'd0);
      chk("oor_nowrite", rd_g, 64'h000000005A5A5A5A);
      issue(1'b0, 2'd3, 1'b0, 64'hF8, 64'd0);
      chk("ld_last_ok", 64'(er_g), 64'd0);
      issue(1'b0, 2'd3, 1'b0, 64'hFFFFFFFFFFFFFFF8, 64'd0);
      chk("ld_nowrap_err", 64'(er_g), 64'd1);

      // reset while a split load is in its second cycle
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_we = 1'b0;
      bus.req_size = 2'd2;
      bus.req_unsigned = 1'b1;
      bus.req_addr = 64'h0E;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      chk("mid_split_ready", 64'(bus.req_ready), 64'd0);
      rst_n = 1'b0;
      #1;
      chk("abort_ready", 64'(bus.req_ready), 64'd1);
      chk("abort_rvalid", 64'(bus.resp_valid), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         seen = seen | bus.resp_valid;
      end
      chk("abort_no_resp", 64'(seen), 64'd0);
      issue(1'b0, 2'd3, 1'b0, 64'h10, 64'd0);
      chk("post_rst_lat", 64'(lat_g), 64'd1);
      chk("post_rst_data", rd_g, 64'h112233445566AABB);
`else
      issue(1'b1, 2'd3, 1'b0, 64'h00, 64'h0807060504030201);
      chk("sd_err", 64'(er_g), 64'd0);
      issue(1'b0, 2'd1, 1'b0, 64'h03, 64'd0);
      chk("lh_mis_ready", 64'(rdy_g), 64'd1);
      chk("lh_mis_lat", 64'(lat_g), 64'd1);
      chk("lh_mis_err", 64'(er_g), 64'd1);
      chk("lh_mis_rdata", rd_g, 64'd0);
      issue(1'b0, 2'd1, 1'b0, 64'h02, 64'd0);
      chk("lh_al_err", 64'(er_g), 64'd0);
      chk("lh_al_data", rd_g, 64'h0403);
      issue(1'b1, 2'd2, 1'b0, 64'h06, 64'h00000000AABBCCDD);
      chk("sw_mis_err", 64'(er_g), 64'd1);
      issue(1'b0, 2'd3, 1'b0, 64'h00, 64'd0);
      chk("sw_mis_nowrite", rd_g, 64'h0807060504030201);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/dmem_lsu_ctrl.md
Name: dmem_lsu_ctrl

Overview:
Parametrised byte-addressable data memory with a load/store front end for the MEM stage of the pipelined RISC-V core.
- Supports byte, half, word and doubleword accesses, with sign/zero extension on loads.
- Handles misaligned accesses that straddle a doubleword boundary by splitting them into two internal cycles.
- Flags out-of-range addresses.
- Storage is a banked 64-bit-wide RAM with byte enables.
- Uses a valid/ready request handshake and a registered response.

Parameters:
XLEN, 64, data width in bits (fixed 64 for RV64; 32 allowed, which makes size=3 illegal).
DEPTH_BYTES, 256, memory size in bytes; power of 2, multiple of XLEN/8.
ADDR_W, 64, width of the request address.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  request present.
req_ready  out  1  controller can accept a request this cycle.
req_we  in  1  1=store, 0=load.
req_size  in  2  0=byte, 1=half, 2=word, 3=dword.
req_unsigned  in  1  loads only: 1=zero-extend, 0=sign-extend.
req_addr  in  ADDR_W  byte address.
req_wdata  in  XLEN  store data, LSB-aligned.
resp_valid  out  1  one-cycle pulse: response/ack valid.
resp_rdata  out  XLEN  extended load data; 0 for stores and errors.
resp_err  out  1  qualifies resp_valid; access was rejected.

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, pending split registers cleared. Memory contents are NOT reset.
- Access geometry:
  - nbytes = 1<<req_size.
  - off = addr[2:0].
  - A request is a split when off+nbytes > 8.
- Range check, done at accept: error if addr+nbytes-1 >= DEPTH_BYTES, or if size=3 with XLEN=32.
  - Address arithmetic is unsigned in ADDR_W+1 bits, so there is no wrap-around.
  - An error request causes no write; resp_err=1 and resp_rdata=0 at N+1; the FSM stays IDLE.
- FSM states: IDLE, SPLIT.
  - req_ready = (state==IDLE).
  - The handshake fires when req_valid && req_ready.
- IDLE, non-split, accepted at edge N:
  - Bank access with the byte-enable mask shifted by off.
  - resp_valid=1 at N+1.
  - Load data = word >> (8*off), truncated to nbytes, extended per req_unsigned.
- IDLE, split, accepted at edge N:
  - Cycle N: first doubleword accessed with the low bytes (bytes off..7). Request fields are latched. Transition to SPLIT.
  - SPLIT, edge N+1: next doubleword accessed with the remaining bytes (bytes 0..off+nbytes-9). Return to IDLE.
  - resp_valid=1 at N+2. Load data is the concatenation of both parts.
  - req_valid is ignored while in SPLIT.
- Stores:
  - Write only the enabled bytes; untouched bytes keep their value.
  - resp_valid pulses as an ack with resp_rdata=0.
- Read-after-write: a load accepted at the edge after a store to the same bytes returns the new data. No same-edge hazard exists, because accepts are serialised.
- Responses have no backpressure; the consumer must take resp_valid when it pulses. resp_valid never holds for two cycles from one request.
- Reset mid-SPLIT: the operation is aborted with no response. For a split store, the first half is already written and the second half is not; this is documented, not corrected.
- Back-to-back non-split requests: one accepted per cycle, one response per cycle.

Optional Feature:
Macro DMEM_MISALIGN_TRAP_EN.
- Defined: any access with addr not a multiple of nbytes returns resp_err=1 at N+1, performs no write, and never enters SPLIT. The SPLIT state logic is compiled out and req_ready is tied to 1.
- Undefined: misaligned accesses are supported via the split behaviour above.

Decomposition:
- Package dmem_pkg:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D;
  - FSM state enum;
  - function for byte-enable generation;
  - function for load extension (data, size, unsigned).
- Sub-module dmem_bank: synchronous single-port RAM, DEPTH_BYTES/8 words of 64 bits, 8 byte-enables, registered read.

Test Plan:
1. SD 0x1122334455667788 at addr 0x10, then LD 0x10 -> ack with err=0; load returns 0x1122334455667788 one cycle after accept.
2. LB signed at 0x10 after byte 0x10 was set to 0xF4 -> 0xFFFFFFFFFFFFFFF4. LBU at the same address -> 0x00000000000000F4.
3. SW 0xAABBCCDD at 0x0E (split; macro undefined) -> resp_valid two cycles after accept, req_ready low for one cycle. LWU 0x0E -> 0xAABBCCDD. Bytes 0x0D and 0x12 are unchanged.
4. LD at DEPTH_BYTES-4 -> resp_err=1, rdata=0, no memory change. Repeat as a store -> no bytes written.
5. Assert rst_n=0 during SPLIT of a load -> no resp_valid is produced, req_ready=1 after release, and the next LD works normally.
6. With DMEM_MISALIGN_TRAP_EN defined: LH at 0x03 -> resp_err=1 at N+1, no split. LH at 0x02 -> normal result.
